// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core.
// Walks each instruction through FETCH, DECODE, EXEC, (MEM), WB and
// drives the datapath enables. Illegal encodings and memory timeouts
// park the sequencer in a sticky TRAP state until rst.
//
// Handshake: imem_req/mem_re/mem_we are held high while waiting; the
// matching *_ready input completes the access in the cycle it is seen high.
// A wait that reaches MEM_TIMEOUT cycles without ready traps with bus_err.
// A ready seen in that last cycle still completes the access.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic [2:0]  state,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic        retire,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPI, C_LD, C_ST, C_JAL, C_JALR, C_AUIPC, C_LUI, C_BR
  } cls_t;

  // Index of the last allowed wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     st;
  cls_t       cls;
  logic [7:0] wcnt;
  cls_t       dec_cls;
  logic       dec_ok;
  logic       wait_last;

  assign state     = st;
  assign wait_last = (wcnt == WAIT_LAST);

  // Classify the opcode/funct3 pair and flag illegal encodings.
  always_comb begin
    dec_cls = C_OP;
    dec_ok  = 1'b1;
    case (opcode)
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: begin
        dec_cls = C_JALR;
        dec_ok  = (funct3 == 3'b000);
      end
      7'b1100011: begin
        dec_cls = C_BR;
        dec_ok  = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      7'b0000011: begin
        dec_cls = C_LD;
        dec_ok  = !((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
      end
      7'b0100011: begin
        dec_cls = C_ST;
        dec_ok  = (funct3 < 3'b011);
      end
      7'b0010011: dec_cls = C_OPI;
      7'b0110011: dec_cls = C_OP;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Datapath controls from the current state, latched class and handshakes.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    retire    = 1'b0;
    if (!rst) begin
      case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          case (cls)
            C_OPI, C_LD, C_ST, C_JALR: alu_src_b = 1'b1;
            C_AUIPC: begin
              alu_src_a = 2'd1;
              alu_src_b = 1'b1;
            end
            C_LUI: begin
              alu_src_a = 2'd2;
              alu_src_b = 1'b1;
            end
            C_BR: begin
              pc_we  = 1'b1;
              retire = 1'b1;
              pc_sel = branch_taken ? 2'd1 : 2'd0;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (cls == C_LD) begin
            mem_re = 1'b1;
          end else begin
            mem_we = 1'b1;
            pc_we  = dmem_ready;
            retire = dmem_ready;
          end
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          case (cls)
            C_LD: wb_sel = 2'd1;
            C_JAL: begin
              wb_sel = 2'd2;
              pc_sel = 2'd1;
            end
            C_JALR: begin
              wb_sel = 2'd2;
              pc_sel = 2'd2;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Sequencer state, op class, wait counter, sticky flags and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_FETCH;
      cls     <= C_OP;
      wcnt    <= 8'd0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      instret <= 32'd0;
    end else begin
      if (retire) instret <= instret + 32'd1;
      case (st)
        S_FETCH: begin
          if (imem_ready) begin
            st   <= S_DECODE;
            wcnt <= 8'd0;
          end else if (wait_last) begin
            bus_err <= 1'b1;
            st      <= S_TRAP;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_ok) begin
            st <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            st      <= S_TRAP;
          end
        end
        S_EXEC: begin
          wcnt <= 8'd0;
          if (cls == C_BR)                     st <= S_FETCH;
          else if (cls == C_LD || cls == C_ST) st <= S_MEM;
          else                                 st <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            wcnt <= 8'd0;
            st   <= (cls == C_LD) ? S_WB : S_FETCH;
          end else if (wait_last) begin
            bus_err <= 1'b1;
            st      <= S_TRAP;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_WB: begin
          wcnt <= 8'd0;
          st   <= S_FETCH;
        end
        default: st <= S_TRAP;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB using the opcode and funct3 fields from the instruction decoder.
- Drives the PC, IR, register-file, ALU-mux and memory enables, and waits on instruction and data memory handshakes.
- Flags illegal encodings and memory timeouts by entering a sticky trap state.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles on imem_ready or dmem_ready before a bus-error trap; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  7  instruction opcode from the decoder; valid from DECODE onward.
- funct3  in  3  funct3 field from the decoder.
- branch_taken  in  1  branch compare result from the ALU; valid in EXEC.
- imem_ready  in  1  instruction word is available this cycle.
- dmem_ready  in  1  data access completes this cycle.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  latch the instruction register.
- pc_we  out  1  update the PC.
- pc_sel  out  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR).
- alu_src_a  out  2  ALU operand A: 0 = rs1, 1 = PC, 2 = zero.
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = imm.
- mem_re  out  1  data read request.
- mem_we  out  1  data write request.
- reg_we  out  1  register-file write enable.
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4.
- illegal  out  1  sticky: illegal instruction trap.
- bus_err  out  1  sticky: memory timeout trap.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset:
  - state = FETCH; instret = 0; illegal = bus_err = 0.
  - Internal op class and wait counter cleared.
  - All enables are 0 during the reset cycle.
  - Reset at any point, including mid-MEM or in TRAP, aborts the instruction with no PC or register write.
- Outputs are combinational from state, the latched op class, the ready inputs and branch_taken. The state, counter and flag registers update on the rising edge of clk.
- FETCH:
  - imem_req = 1 throughout.
  - When imem_ready = 1: ir_we = 1, wait counter cleared, next state DECODE.
  - If imem_ready is still 0 after MEM_TIMEOUT waited cycles: bus_err set, next state TRAP.
- DECODE: single cycle. Opcode and funct3 are classified and the op class is latched.
  - LUI 0110111: class LUI.
  - AUIPC 0010111: class AUIPC.
  - JAL 1101111: class JAL.
  - JALR 1100111: class JALR; only funct3 = 000 is legal.
  - BRANCH 1100011: class BR; funct3 = 010 and 011 are illegal.
  - LOAD 0000011: class LD; funct3 = 011, 110 and 111 are illegal.
  - STORE 0100011: class ST; funct3 >= 011 is illegal.
  - OP-IMM 0010011: class OPI.
  - OP 0110011: class OP.
  - Any other opcode, or any illegal funct3 above: illegal set, next state TRAP.
  - Otherwise next state EXEC.
- EXEC, ALU mux settings per class:
  - OP: alu_src_a = 0, alu_src_b = 0.
  - OPI, LD, ST, JALR: alu_src_a = 0, alu_src_b = 1.
  - AUIPC: alu_src_a = 1, alu_src_b = 1.
  - LUI: alu_src_a = 2, alu_src_b = 1.
  - BR: alu_src_a = 0, alu_src_b = 0.
- EXEC, sequencing per class:
  - BR: pc_we = 1 and retire = 1. pc_sel = 1 if branch_taken, otherwise pc_sel = 0. Next state FETCH.
  - LD, ST: next state MEM with the wait counter cleared.
  - All other classes: next state WB.
- MEM:
  - LD: mem_re = 1 held until dmem_ready. On dmem_ready, next state WB.
  - ST: mem_we = 1 held until dmem_ready. On dmem_ready: pc_we = 1, pc_sel = 0, retire = 1, next state FETCH.
  - Timeout after MEM_TIMEOUT waited cycles: bus_err set, next state TRAP, no pc_we or reg_we.
  - A ready arriving on exactly the timeout cycle counts as success.
- WB: always reg_we = 1, pc_we = 1, retire = 1, next state FETCH.
  - LD: wb_sel = 1, pc_sel = 0.
  - JAL: wb_sel = 2, pc_sel = 1.
  - JALR: wb_sel = 2, pc_sel = 2.
  - All other classes: wb_sel = 0, pc_sel = 0.
- TRAP: absorbing until rst. All enables are 0, retire = 0, and illegal and bus_err hold their values.
- instret:
  - Increments by 1 on each cycle where retire = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Retire pulses are never merged; at most one occurs per cycle.
- Latency with zero-wait memories:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BR: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.

Test Plan:
- Zero-wait memories, OP 0110011 then OPI 0010011 -> state sequence 0,1,2,4,0,...; reg_we = 1, wb_sel = 0 and retire pulse in WB; instret = 2 after 8 cycles.
- BEQ with branch_taken = 1, then BNE with branch_taken = 0 -> pc_sel = 1 then pc_sel = 0; each branch retires in EXEC after 3 cycles; no reg_we.
- LOAD funct3 = 010 with dmem_ready delayed 3 cycles -> mem_re high for 4 cycles, then WB with wb_sel = 1; total latency 8 cycles. JALR funct3 = 000 -> WB with wb_sel = 2, pc_sel = 2.
- Opcode 1110011, and separately STORE funct3 = 011 -> TRAP (state = 5) entered after DECODE; illegal = 1; no further enables; rst then returns to state 0 with instret = 0.
- MEM_TIMEOUT = 4 with dmem_ready never asserted on a store -> bus_err = 1 and TRAP after 4 wait cycles, no pc_we. Repeat with ready on wait cycle 4 -> store retires normally.
- Assert rst mid-MEM with mem_re = 1 -> next cycle state = FETCH, mem_re = 0, instret unchanged-from-reset at 0, no reg_we.
